// File: rtl/div_pkg.sv
// Shared types and sizing constants for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step.
// Shifts {R,Q} left by one, trial-subtracts the divisor from R and either keeps
// the difference (quotient bit 1) or restores the shifted R (quotient bit 0).
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH+1:0] sum;
    logic             borrow;
    logic             rem_msb_unused;

    // The partial remainder is always below the divisor, so its top bit is
    // zero going in and is shifted out here.
    assign rem_msb_unused = rem[WIDTH];

    // Shift, subtract as R + ~{0,b} + 1 so a set carry-out means no borrow.
    always_comb begin
        rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_sh   = {quo[WIDTH-2:0], 1'b0};
        sum      = {1'b0, rem_sh} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
        borrow   = ~sum[WIDTH+1];
        rem_next = borrow ? rem_sh : sum[WIDTH:0];
        quo_next = {quo_sh[WIDTH-1:1], ~borrow};
    end

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider with RISC-V M semantics (DIV/DIVU/REM/REMU).
// One quotient bit per clock, a final sign-fix cycle, and a valid/ready
// handshake on both the request and the result side.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign accept  = valid_i & ready_o;

    // Cases that are answered directly at accept instead of iterating.
    assign div_zero = (divisor_i == '0);
    assign overflow = signed_i & (dividend_i == MOST_NEG) & (&divisor_i);
    assign special  = div_zero | overflow;

    // Magnitudes for the unsigned core; the most negative value negates to
    // itself, which is still its correct unsigned magnitude.
    assign sign_a = signed_i & dividend_i[WIDTH-1];
    assign sign_b = signed_i & divisor_i[WIDTH-1];
    assign abs_a  = sign_a ? -dividend_i : dividend_i;
    assign abs_b  = sign_b ? -divisor_i  : divisor_i;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dsr_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a result pop always returns to IDLE for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand load, iteration, sign fix and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (special) begin
                            quotient_o  <= div_zero ? '1 : dividend_i;
                            remainder_o <= div_zero ? dividend_i : '0;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            dsr_q   <= abs_b;
                            cnt     <= CNT_INIT;
                            neg_quo <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    quotient_o  <= neg_quo ? -quo_q : quo_q;
                    remainder_o <= neg_rem ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed, table-driven bench for the iterative divider.
module tb_div32_seq;

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] lat;
    } vec_t;

    localparam int NUM_VECS = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int assertions = 0;
    int failures   = 0;

    vec_t vecs [NUM_VECS];

    div32_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request, then waits (bounded) for valid_o. lat counts the
    // accept edge plus every edge up to the one after which valid_o is seen.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic rdy_low);
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        valid_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i    = 1'b0;
        signed_i   = ~sgn;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        lat        = 1;
        rdy_low    = 1'b1;
        while (!valid_o && lat < 100) begin
            if (ready_o) rdy_low = 1'b0;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic popResult();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        rdy_low;
        string       tag;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         32'd34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD,  32'hFFFFFFFF,  32'd34};
        vecs[2]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000001,  32'd34};
        vecs[3]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         32'd1};
        vecs[4]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         32'd1};
        vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h00000000,  32'd1};
        vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  32'h80000000,  32'd34};
        vecs[7]  = '{1'b0, 32'd0,         32'd9,         32'd0,         32'd0,         32'd34};
        vecs[8]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         32'd34};
        vecs[9]  = '{1'b0, 32'hDEADBEEF,  32'd1,         32'hDEADBEEF,  32'd0,         32'd34};
        vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  32'd34};
        vecs[11] = '{1'b1, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         32'd34};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         32'd34};
        vecs[13] = '{1'b1, 32'h80000000,  32'h80000000,  32'd1,         32'd0,         32'd34};
        vecs[14] = '{1'b1, 32'd0,         32'hFFFFFFFF,  32'd0,         32'd0,         32'd34};
        vecs[15] = '{1'b0, 32'd1000,      32'hFFFFFFFF,  32'd0,         32'd1000,      32'd34};

        rst_ni     = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;

        repeat (3) @(negedge clk_i);
        checkOutput("reset ready_o", {31'd0, ready_o}, 32'd1);
        checkOutput("reset valid_o", {31'd0, valid_o}, 32'd0);
        checkOutput("reset quotient", quotient_o, 32'd0);
        checkOutput("reset remainder", remainder_o, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, rdy_low);
            $sformat(tag, "vec%0d", i);
            checkOutput({tag, " quotient"}, quotient_o, vecs[i].q);
            checkOutput({tag, " remainder"}, remainder_o, vecs[i].r);
            checkOutput({tag, " latency"}, 32'(lat), vecs[i].lat);
            if (vecs[i].lat > 32'd1) begin
                checkOutput({tag, " ready_o low while busy"}, {31'd0, rdy_low}, 32'd1);
            end
            popResult();
            checkOutput({tag, " ready_o after pop"}, {31'd0, ready_o}, 32'd1);
            checkOutput({tag, " valid_o after pop"}, {31'd0, valid_o}, 32'd0);
        end

        // Backpressure: results held, new requests ignored while in DONE.
        applyStimulus(1'b0, 32'd100, 32'd7, lat, rdy_low);
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        valid_i    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkOutput("bp valid_o held", {31'd0, valid_o}, 32'd1);
            checkOutput("bp ready_o low", {31'd0, ready_o}, 32'd0);
            checkOutput("bp quotient", quotient_o, 32'd14);
            checkOutput("bp remainder", remainder_o, 32'd2);
        end
        valid_i = 1'b0;
        popResult();
        checkOutput("bp ready_o after pop", {31'd0, ready_o}, 32'd1);
        checkOutput("bp valid_o after pop", {31'd0, valid_o}, 32'd0);
        checkOutput("bp quotient kept", quotient_o, 32'd14);
        checkOutput("bp remainder kept", remainder_o, 32'd2);

        // Reset in the middle of an iteration.
        @(negedge clk_i);
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        valid_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checkOutput("midcalc busy", {31'd0, ready_o}, 32'd0);
        rst_ni = 1'b0;
        #1;
        checkOutput("midcalc reset ready_o", {31'd0, ready_o}, 32'd1);
        checkOutput("midcalc reset valid_o", {31'd0, valid_o}, 32'd0);
        checkOutput("midcalc reset quotient", quotient_o, 32'd0);
        checkOutput("midcalc reset remainder", remainder_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'h10, lat, rdy_low);
        checkOutput("post-reset quotient", quotient_o, 32'h0FFFFFFF);
        checkOutput("post-reset remainder", remainder_o, 32'h0000000F);
        checkOutput("post-reset latency", 32'(lat), 32'd34);
        popResult();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
